// File: rtl/id_ex_stage_pkg.sv
// Shared core definitions for the ID/EX pipeline register: datapath widths,
// ALU op encoding, control bundle, ID/EX payload struct and the WB bypass helper.
package id_ex_stage_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned ALUOP_W    = 4;

    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_SLL  = 4'h2,
        ALU_SLT  = 4'h3,
        ALU_SLTU = 4'h4,
        ALU_XOR  = 4'h5,
        ALU_SRL  = 4'h6,
        ALU_SRA  = 4'h7,
        ALU_OR   = 4'h8,
        ALU_AND  = 4'h9,
        ALU_LUI  = 4'hA
    } aluop_e;

    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   alusrc;
        logic   branch;
        logic   jump;
        aluop_e aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        ctrl_t                 ctrl;
    } id_ex_t;

    // A bubble carries zero indices so EX forwarding can never match it.
    localparam id_ex_t ID_EX_BUBBLE = '{
        valid:    1'b0,
        pc:       '0,
        rs1:      '0,
        rs2:      '0,
        rd:       '0,
        rs1_data: '0,
        rs2_data: '0,
        imm:      '0,
        ctrl:     CTRL_BUBBLE
    };

    // WB-to-ID bypass: x0 never matches because wb_rd must be non-zero.
    function automatic logic [XLEN-1:0] wb_bypass(
        input logic                  wb_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic [XLEN-1:0]       wb_data,
        input logic [REG_ADDR_W-1:0] rs,
        input logic [XLEN-1:0]       rf_data
    );
        return (wb_we && (wb_rd != '0) && (wb_rd == rs)) ? wb_data : rf_data;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID -> ID/EX -> EX bundle.
//   id_*_i    : decoded instruction fields presented by ID
//   id_ex_*_o : registered EX-side copies produced by the ID/EX stage
// master: the surrounding pipeline (drives ID fields, consumes EX copies)
// slave : the ID/EX stage itself
interface id_ex_stage_if #(
    parameter int unsigned XLEN    = id_ex_stage_pkg::XLEN,
    parameter int unsigned ALUOP_W = id_ex_stage_pkg::ALUOP_W
);
    localparam int unsigned RW = id_ex_stage_pkg::REG_ADDR_W;

    logic               id_valid_i;
    logic [XLEN-1:0]    id_pc_i;
    logic [RW-1:0]      id_rs1_i;
    logic [RW-1:0]      id_rs2_i;
    logic [RW-1:0]      id_rd_i;
    logic               id_uses_rs1_i;
    logic               id_uses_rs2_i;
    logic [XLEN-1:0]    id_rs1_data_i;
    logic [XLEN-1:0]    id_rs2_data_i;
    logic [XLEN-1:0]    id_imm_i;
    logic               id_regwrite_i;
    logic               id_memread_i;
    logic               id_memwrite_i;
    logic               id_memtoreg_i;
    logic               id_alusrc_i;
    logic               id_branch_i;
    logic               id_jump_i;
    logic [ALUOP_W-1:0] id_aluop_i;

    logic               id_ex_valid_o;
    logic [XLEN-1:0]    id_ex_pc_o;
    logic [RW-1:0]      id_ex_rs1_o;
    logic [RW-1:0]      id_ex_rs2_o;
    logic [RW-1:0]      id_ex_rd_o;
    logic [XLEN-1:0]    id_ex_rs1_data_o;
    logic [XLEN-1:0]    id_ex_rs2_data_o;
    logic [XLEN-1:0]    id_ex_imm_o;
    logic               id_ex_regwrite_o;
    logic               id_ex_memread_o;
    logic               id_ex_memwrite_o;
    logic               id_ex_memtoreg_o;
    logic               id_ex_alusrc_o;
    logic               id_ex_branch_o;
    logic               id_ex_jump_o;
    logic [ALUOP_W-1:0] id_ex_aluop_o;

    modport master (
        output id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_uses_rs1_i, id_uses_rs2_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i,
               id_alusrc_i, id_branch_i, id_jump_i, id_aluop_i,
        input  id_ex_valid_o, id_ex_pc_o, id_ex_rs1_o, id_ex_rs2_o, id_ex_rd_o,
               id_ex_rs1_data_o, id_ex_rs2_data_o, id_ex_imm_o,
               id_ex_regwrite_o, id_ex_memread_o, id_ex_memwrite_o, id_ex_memtoreg_o,
               id_ex_alusrc_o, id_ex_branch_o, id_ex_jump_o, id_ex_aluop_o
    );

    modport slave (
        input  id_valid_i, id_pc_i, id_rs1_i, id_rs2_i, id_rd_i,
               id_uses_rs1_i, id_uses_rs2_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i,
               id_alusrc_i, id_branch_i, id_jump_i, id_aluop_i,
        output id_ex_valid_o, id_ex_pc_o, id_ex_rs1_o, id_ex_rs2_o, id_ex_rd_o,
               id_ex_rs1_data_o, id_ex_rs2_data_o, id_ex_imm_o,
               id_ex_regwrite_o, id_ex_memread_o, id_ex_memwrite_o, id_ex_memtoreg_o,
               id_ex_alusrc_o, id_ex_branch_o, id_ex_jump_o, id_ex_aluop_o
    );

endinterface

// File: rtl/id_ex_stage_load_use_detector.sv
// Load-use hazard detector (purely combinational).
//   ex_*_i    : load currently held in ID/EX
//   id_*_i    : instruction currently in ID
//   hazard_o  : ID instruction reads the register the EX load is about to write
module id_ex_stage_load_use_detector
    import id_ex_stage_pkg::*;
(
    input  logic                  ex_valid_i,
    input  logic                  ex_memread_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  id_valid_i,
    input  logic                  id_uses_rs1_i,
    input  logic                  id_uses_rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    output logic                  hazard_o
);

    logic rs1_hit;
    logic rs2_hit;

    // Only operands the instruction actually reads count as dependencies.
    assign rs1_hit  = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
    assign rs2_hit  = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
    assign hazard_o = ex_valid_i && ex_memread_i && (ex_rd_i != '0) && id_valid_i
                      && (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and WB-to-ID bypass.
//   clk, rst_n        : clock, asynchronous active-low reset
//   hold_i            : freeze everything (including the bubble counter)
//   flush_i           : squash the ID instruction (taken branch/jump in EX)
//   wb_*_i            : WB register-file write, bypassed into captured operands
//   bus (slave)       : ID fields in, registered id_ex_* copies out
//   load_use_stall_o  : combinational; hold PC and IF/ID this cycle
//   bubble_cnt_o      : saturating count of inserted load-use bubbles
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN    = id_ex_stage_pkg::XLEN,
    parameter int unsigned ALUOP_W = id_ex_stage_pkg::ALUOP_W,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                hold_i,
    input  logic                                flush_i,
    input  logic                                wb_regwrite_i,
    input  logic [id_ex_stage_pkg::REG_ADDR_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]                     wb_data_i,
    id_ex_stage_if.slave                        bus,
    output logic                                load_use_stall_o,
    output logic [CNT_W-1:0]                    bubble_cnt_o
);

    id_ex_t           ex_q;
    id_ex_t           ex_d;
    id_ex_t           id_word;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             hz;
    logic [XLEN-1:0]  rs1_data_byp;
    logic [XLEN-1:0]  rs2_data_byp;
    logic [ALUOP_W-1:0] aluop_in;

    id_ex_stage_load_use_detector u_load_use_detector (
        .ex_valid_i    (ex_q.valid),
        .ex_memread_i  (ex_q.ctrl.memread),
        .ex_rd_i       (ex_q.rd),
        .id_valid_i    (bus.id_valid_i),
        .id_uses_rs1_i (bus.id_uses_rs1_i),
        .id_uses_rs2_i (bus.id_uses_rs2_i),
        .id_rs1_i      (bus.id_rs1_i),
        .id_rs2_i      (bus.id_rs2_i),
        .hazard_o      (hz)
    );

    // A flush kills the dependent instruction, so there is nothing to stall for.
    assign load_use_stall_o = hz && !flush_i;

    // Operands as seen after the WB bypass.
    assign rs1_data_byp = wb_bypass(wb_regwrite_i, wb_rd_i, wb_data_i, bus.id_rs1_i, bus.id_rs1_data_i);
    assign rs2_data_byp = wb_bypass(wb_regwrite_i, wb_rd_i, wb_data_i, bus.id_rs2_i, bus.id_rs2_data_i);
    assign aluop_in     = bus.id_aluop_i;

    // Normal-load payload; side-effecting controls are gated by id_valid_i.
    always_comb begin
        id_word               = ID_EX_BUBBLE;
        id_word.valid         = bus.id_valid_i;
        id_word.pc            = bus.id_pc_i;
        id_word.rs1           = bus.id_rs1_i;
        id_word.rs2           = bus.id_rs2_i;
        id_word.rd            = bus.id_rd_i;
        id_word.rs1_data      = rs1_data_byp;
        id_word.rs2_data      = rs2_data_byp;
        id_word.imm           = bus.id_imm_i;
        id_word.ctrl.regwrite = bus.id_regwrite_i && bus.id_valid_i;
        id_word.ctrl.memread  = bus.id_memread_i  && bus.id_valid_i;
        id_word.ctrl.memwrite = bus.id_memwrite_i && bus.id_valid_i;
        id_word.ctrl.branch   = bus.id_branch_i   && bus.id_valid_i;
        id_word.ctrl.jump     = bus.id_jump_i     && bus.id_valid_i;
        id_word.ctrl.memtoreg = bus.id_memtoreg_i;
        id_word.ctrl.alusrc   = bus.id_alusrc_i;
        id_word.ctrl.aluop    = aluop_e'(aluop_in);
    end

    // Update priority: hold > flush > hazard > normal load.
    always_comb begin
        ex_d  = ex_q;
        cnt_d = cnt_q;
        if (!hold_i) begin
            if (flush_i) begin
                ex_d = ID_EX_BUBBLE;
            end else if (hz) begin
                ex_d = ID_EX_BUBBLE;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                ex_d = id_word;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q  <= ID_EX_BUBBLE;
            cnt_q <= '0;
        end else begin
            ex_q  <= ex_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.id_ex_valid_o    = ex_q.valid;
    assign bus.id_ex_pc_o       = ex_q.pc;
    assign bus.id_ex_rs1_o      = ex_q.rs1;
    assign bus.id_ex_rs2_o      = ex_q.rs2;
    assign bus.id_ex_rd_o       = ex_q.rd;
    assign bus.id_ex_rs1_data_o = ex_q.rs1_data;
    assign bus.id_ex_rs2_data_o = ex_q.rs2_data;
    assign bus.id_ex_imm_o      = ex_q.imm;
    assign bus.id_ex_regwrite_o = ex_q.ctrl.regwrite;
    assign bus.id_ex_memread_o  = ex_q.ctrl.memread;
    assign bus.id_ex_memwrite_o = ex_q.ctrl.memwrite;
    assign bus.id_ex_memtoreg_o = ex_q.ctrl.memtoreg;
    assign bus.id_ex_alusrc_o   = ex_q.ctrl.alusrc;
    assign bus.id_ex_branch_o   = ex_q.ctrl.branch;
    assign bus.id_ex_jump_o     = ex_q.ctrl.jump;
    assign bus.id_ex_aluop_o    = ex_q.ctrl.aluop;
    assign bubble_cnt_o         = cnt_q;

endmodule
